// File: rtl/read_data_router.sv
// AXI R-channel router for the 2-master/3-slave crossbar: returns slave bursts to the
// master named by the tag in the slave-side RID, one whole burst at a time, round-robin.

module read_data_router_mport #(
  parameter int ID_W   = 4,
  parameter int DATA_W = 32
) (
  input  logic              route_en,
  input  logic              vld_in,
  input  logic [ID_W-1:0]   id_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [1:0]        resp_in,
  input  logic              last_in,
  input  logic              rready,
  output logic              rvalid,
  output logic [ID_W-1:0]   rid,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              take
);
  // A master not owning the channel sees an all-zero R bus.
  assign rvalid = route_en & vld_in;
  assign rid    = route_en ? id_in   : '0;
  assign rdata  = route_en ? data_in : '0;
  assign rresp  = route_en ? resp_in : '0;
  assign rlast  = route_en & last_in;
  assign take   = route_en & rready;
endmodule

module read_data_router #(
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDS_W-1:0]  RID_S0,
  input  logic [DATA_W-1:0] RDATA_S0,
  input  logic [1:0]        RRESP_S0,
  input  logic              RLAST_S0,
  input  logic              RVALID_S0,
  output logic              RREADY_S0,
  input  logic [IDS_W-1:0]  RID_S1,
  input  logic [DATA_W-1:0] RDATA_S1,
  input  logic [1:0]        RRESP_S1,
  input  logic              RLAST_S1,
  input  logic              RVALID_S1,
  output logic              RREADY_S1,
  input  logic [IDS_W-1:0]  RID_S2,
  input  logic [DATA_W-1:0] RDATA_S2,
  input  logic [1:0]        RRESP_S2,
  input  logic              RLAST_S2,
  input  logic              RVALID_S2,
  output logic              RREADY_S2,
  output logic [ID_W-1:0]   RID_M0,
  output logic [DATA_W-1:0] RDATA_M0,
  output logic [1:0]        RRESP_M0,
  output logic              RLAST_M0,
  output logic              RVALID_M0,
  input  logic              RREADY_M0,
  output logic [ID_W-1:0]   RID_M1,
  output logic [DATA_W-1:0] RDATA_M1,
  output logic [1:0]        RRESP_M1,
  output logic              RLAST_M1,
  output logic              RVALID_M1,
  input  logic              RREADY_M1
);
  localparam int NUM_S = 3;
  localparam int NUM_M = 2;
  localparam int TAG_W = IDS_W - ID_W;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  logic [NUM_S-1:0]             s_vld, s_last, s_rdy;
  logic [NUM_S-1:0][IDS_W-1:0]  s_id;
  logic [NUM_S-1:0][DATA_W-1:0] s_data;
  logic [NUM_S-1:0][1:0]        s_resp;

  assign s_vld  = {RVALID_S2, RVALID_S1, RVALID_S0};
  assign s_last = {RLAST_S2, RLAST_S1, RLAST_S0};
  assign s_id   = {RID_S2, RID_S1, RID_S0};
  assign s_data = {RDATA_S2, RDATA_S1, RDATA_S0};
  assign s_resp = {RRESP_S2, RRESP_S1, RRESP_S0};
  assign {RREADY_S2, RREADY_S1, RREADY_S0} = s_rdy;

  state_t           state, state_nxt;
  logic [1:0]       sel, sel_nxt, rr_ptr, rr_ptr_nxt;
  logic [1:0]       pick, cand;
  logic             pick_vld;
  logic [TAG_W-1:0] dst, dst_nxt, pick_tag;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // First valid slave at or after rr_ptr, wrapping S2 -> S0.
  always_comb begin
    pick_vld = 1'b0;
    pick     = rr_ptr;
    cand     = rr_ptr;
    for (int k = 0; k < NUM_S; k++) begin
      if (!pick_vld && s_vld[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
      cand = inc3(cand);
    end
  end

  assign pick_tag = s_id[pick][IDS_W-1:ID_W];

  logic              c_vld, c_last;
  logic [ID_W-1:0]   c_id;
  logic [DATA_W-1:0] c_data;
  logic [1:0]        c_resp;

  always_comb begin
    c_vld  = 1'b0;
    c_last = 1'b0;
    c_id   = '0;
    c_data = '0;
    c_resp = '0;
    if (sel < 2'd3) begin
      c_vld  = s_vld[sel];
      c_last = s_last[sel];
      c_id   = s_id[sel][ID_W-1:0];
      c_data = s_data[sel];
      c_resp = s_resp[sel];
    end
  end

  logic [NUM_M-1:0]             route_en, m_take, m_rready, m_rvalid, m_rlast;
  logic [NUM_M-1:0][ID_W-1:0]   m_rid;
  logic [NUM_M-1:0][DATA_W-1:0] m_rdata;
  logic [NUM_M-1:0][1:0]        m_rresp;

  assign m_rready = {RREADY_M1, RREADY_M0};

  for (genvar m = 0; m < NUM_M; m++) begin : g_mport
    assign route_en[m] = (state == BURST) && (dst == TAG_W'(m));
    read_data_router_mport #(.ID_W(ID_W), .DATA_W(DATA_W)) u_mport (
      .route_en (route_en[m]),
      .vld_in   (c_vld),
      .id_in    (c_id),
      .data_in  (c_data),
      .resp_in  (c_resp),
      .last_in  (c_last),
      .rready   (m_rready[m]),
      .rvalid   (m_rvalid[m]),
      .rid      (m_rid[m]),
      .rdata    (m_rdata[m]),
      .rresp    (m_rresp[m]),
      .rlast    (m_rlast[m]),
      .take     (m_take[m])
    );
  end

  assign RVALID_M0 = m_rvalid[0];
  assign RID_M0    = m_rid[0];
  assign RDATA_M0  = m_rdata[0];
  assign RRESP_M0  = m_rresp[0];
  assign RLAST_M0  = m_rlast[0];
  assign RVALID_M1 = m_rvalid[1];
  assign RID_M1    = m_rid[1];
  assign RDATA_M1  = m_rdata[1];
  assign RRESP_M1  = m_rresp[1];
  assign RLAST_M1  = m_rlast[1];

  logic slv_take;

  // Ready reaches only the granted slave; IDLE never drives ready, so no ready-before-grant.
  assign slv_take = (state == DRAIN) || ((state == BURST) && (|m_take));

  always_comb begin
    s_rdy = '0;
    for (int i = 0; i < NUM_S; i++)
      s_rdy[i] = (sel == 2'(i)) && slv_take;
  end

  always_comb begin
    state_nxt  = state;
    sel_nxt    = sel;
    dst_nxt    = dst;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          sel_nxt   = pick;
          dst_nxt   = pick_tag;
          state_nxt = (pick_tag < TAG_W'(NUM_M)) ? BURST : DRAIN;
        end
      end
      BURST, DRAIN: begin
        if (c_vld && c_last && slv_take) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = inc3(sel);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= 2'd0;
      dst    <= '0;
      rr_ptr <= 2'd0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      dst    <= dst_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end
endmodule

// File: tb/tb_read_data_router.sv
// Bench for read_data_router: directed scenarios plus randomized bursts checked
// against transaction-level slave queues.

module tb_read_data_router;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  RID_S0, RID_S1, RID_S2;
  logic [31:0] RDATA_S0, RDATA_S1, RDATA_S2;
  logic [1:0]  RRESP_S0, RRESP_S1, RRESP_S2;
  logic        RLAST_S0, RLAST_S1, RLAST_S2;
  logic        RVALID_S0, RVALID_S1, RVALID_S2;
  logic        RREADY_S0, RREADY_S1, RREADY_S2;
  logic [3:0]  RID_M0, RID_M1;
  logic [31:0] RDATA_M0, RDATA_M1;
  logic [1:0]  RRESP_M0, RRESP_M1;
  logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;

  always #5 clk = ~clk;

  read_data_router #(.ID_W(4), .IDS_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .RID_S0(RID_S0), .RDATA_S0(RDATA_S0), .RRESP_S0(RRESP_S0), .RLAST_S0(RLAST_S0),
    .RVALID_S0(RVALID_S0), .RREADY_S0(RREADY_S0),
    .RID_S1(RID_S1), .RDATA_S1(RDATA_S1), .RRESP_S1(RRESP_S1), .RLAST_S1(RLAST_S1),
    .RVALID_S1(RVALID_S1), .RREADY_S1(RREADY_S1),
    .RID_S2(RID_S2), .RDATA_S2(RDATA_S2), .RRESP_S2(RRESP_S2), .RLAST_S2(RLAST_S2),
    .RVALID_S2(RVALID_S2), .RREADY_S2(RREADY_S2),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1)
  );

  // slave drive (bench-owned) and observed DUT outputs
  logic [7:0]  s_id   [3];
  logic [31:0] s_data [3];
  logic [1:0]  s_resp [3];
  logic [2:0]  s_vld, s_last;
  logic [1:0]  m_rdy;

  assign RID_S0 = s_id[0];   assign RID_S1 = s_id[1];   assign RID_S2 = s_id[2];
  assign RDATA_S0 = s_data[0]; assign RDATA_S1 = s_data[1]; assign RDATA_S2 = s_data[2];
  assign RRESP_S0 = s_resp[0]; assign RRESP_S1 = s_resp[1]; assign RRESP_S2 = s_resp[2];
  assign {RLAST_S2, RLAST_S1, RLAST_S0}    = s_last;
  assign {RVALID_S2, RVALID_S1, RVALID_S0} = s_vld;
  assign {RREADY_M1, RREADY_M0}            = m_rdy;

  logic [2:0]  s_rdy;
  logic [1:0]  m_vld, m_last;
  logic [3:0]  m_id   [2];
  logic [31:0] m_data [2];
  logic [1:0]  m_resp [2];

  assign s_rdy  = {RREADY_S2, RREADY_S1, RREADY_S0};
  assign m_vld  = {RVALID_M1, RVALID_M0};
  assign m_last = {RLAST_M1, RLAST_M0};
  assign m_id[0] = RID_M0;     assign m_id[1] = RID_M1;
  assign m_data[0] = RDATA_M0; assign m_data[1] = RDATA_M1;
  assign m_resp[0] = RRESP_M0; assign m_resp[1] = RRESP_M1;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  beat_t sq [3][$];     // beats each slave still has to deliver
  beat_t rq [2][$];     // beats observed at each master
  int    done_order[$]; // slave index of each completed burst
  int    acc_cnt [3];
  int    owner;
  int    burst_no;
  int    n_chk, n_pass;
  logic [1:0]  prev_vld, prev_rdy;
  logic [31:0] prev_data [2];

  task automatic load_burst(input int s, input logic [7:0] id, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.id   = id;
      b.data = {2'(s), 6'(burst_no), 4'(k), 20'($urandom)};
      b.resp = 2'($urandom);
      b.last = (k == len - 1);
      sq[s].push_back(b);
    end
    burst_no++;
  endtask

  task automatic reset_dut();
    rst = 1'b1; m_rdy = 2'b00; s_vld = 3'b000;
    for (int i = 0; i < 3; i++) begin sq[i].delete(); acc_cnt[i] = 0; end
    rq[0].delete(); rq[1].delete(); done_order.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    owner = -1; prev_vld = 2'b00; prev_rdy = 2'b00;
  endtask

  // One clock of the bench-side slaves and masters, with transaction-level checks.
  task automatic step(input logic [1:0] rdy, input bit gap_en);
    bit    acc [3];
    bit    rcv [3];
    bit    ok;
    beat_t b;
    int    s;
    for (int i = 0; i < 3; i++) begin
      acc[i] = 1'b0; rcv[i] = 1'b0;
      if (!s_vld[i] && sq[i].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
        b = sq[i][0];
        s_vld[i] = 1'b1; s_id[i] = b.id; s_data[i] = b.data; s_resp[i] = b.resp; s_last[i] = b.last;
      end
    end
    m_rdy = rdy;
    #1;
    for (int m = 0; m < 2; m++) begin
      if (prev_vld[m] && !prev_rdy[m]) begin
        n_chk++;
        if (m_vld[m] !== 1'b1 || m_data[m] !== prev_data[m])
          $display("FAIL m%0d_hold: got valid %b data %h, expected valid 1 data %h", m, m_vld[m], m_data[m], prev_data[m]);
        else n_pass++;
      end
    end
    if (m_vld != 2'b00) begin
      n_chk++;
      if (m_vld === 2'b11) $display("FAIL one_master: got valid %b, expected one master at a time", m_vld);
      else n_pass++;
    end
    for (int m = 0; m < 2; m++) begin
      if (m_vld[m] && m_rdy[m]) begin
        s  = int'(m_data[m][31:30]);
        ok = 1'b0;
        if (s < 3 && sq[s].size() > 0) begin
          b  = sq[s][0];
          ok = s_vld[s] && s_rdy[s] && b.data === m_data[m] && b.id[3:0] === m_id[m] &&
               b.id[7:4] === 4'(m) && b.resp === m_resp[m] && b.last === m_last[m];
        end
        n_chk++;
        if (!ok) $display("FAIL m%0d_beat: got id %h data %h last %b, expected current beat of slave %0d", m, m_id[m], m_data[m], m_last[m], s);
        else begin n_pass++; rcv[s] = 1'b1; end
        b.id = {4'(m), m_id[m]}; b.data = m_data[m]; b.resp = m_resp[m]; b.last = m_last[m];
        rq[m].push_back(b);
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (s_vld[i] && s_rdy[i] && sq[i].size() > 0) begin
        b = sq[i][0];
        n_chk++;
        if ((b.id[7:4] < 4'd2 && !rcv[i]) || (owner >= 0 && owner != i))
          $display("FAIL s%0d_accept: got beat %h taken (owner %0d, delivered %b), expected in-order delivery", i, b.data, owner, rcv[i]);
        else n_pass++;
        owner = b.last ? -1 : i;
        if (b.last) done_order.push_back(i);
        acc_cnt[i]++;
        void'(sq[i].pop_front());
        acc[i] = 1'b1;
      end
    end
    prev_vld = m_vld; prev_rdy = m_rdy; prev_data[0] = m_data[0]; prev_data[1] = m_data[1];
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (acc[i]) s_vld[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_rdy = 2'b11;
    s_vld = 3'b001; s_last = 3'b001; s_id[0] = 8'h01; s_data[0] = 32'hDEAD_BEEF; s_resp[0] = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if (s_rdy !== 3'b000) $display("FAIL reset_rready_s: got %b expected 000", s_rdy); else n_pass++;
    n_chk++; if (m_vld !== 2'b00) $display("FAIL reset_rvalid_m: got %b expected 00", m_vld); else n_pass++;
    n_chk++;
    if ({RID_M0, RID_M1, RDATA_M0, RDATA_M1, RRESP_M0, RRESP_M1, m_last} !== '0)
      $display("FAIL reset_payload: got %h %h %h %h expected all 0", RID_M0, RID_M1, RDATA_M0, RDATA_M1);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if ({m_vld, s_rdy} !== 5'b0) $display("FAIL reset_idle: got %b expected 0", {m_vld, s_rdy}); else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (RVALID_M0 !== 1'b1 || RID_M0 !== 4'h1 || RDATA_M0 !== 32'hDEAD_BEEF)
      $display("FAIL reset_first_grant: got vld %b id %h data %h expected 1 1 deadbeef", RVALID_M0, RID_M0, RDATA_M0);
    else n_pass++;
    reset_dut();
  endtask

  task automatic test_single_beat();
    reset_dut();
    s_id[1] = 8'h13; s_data[1] = 32'hA5A5_0013; s_resp[1] = 2'b01; s_last[1] = 1'b1; s_vld[1] = 1'b1;
    m_rdy = 2'b10;
    #1;
    n_chk++; if ({m_vld, s_rdy} !== 5'b0) $display("FAIL single_grant_latency: got %b expected 0", {m_vld, s_rdy}); else n_pass++;
    @(posedge clk); #1;
    n_chk++;
    if (RVALID_M1 !== 1'b1 || RID_M1 !== 4'h3 || RDATA_M1 !== 32'hA5A5_0013 || RRESP_M1 !== 2'b01 || RLAST_M1 !== 1'b1)
      $display("FAIL single_fwd: got vld %b id %h data %h resp %b last %b expected 1 3 a5a50013 01 1", RVALID_M1, RID_M1, RDATA_M1, RRESP_M1, RLAST_M1);
    else n_pass++;
    n_chk++; if (s_rdy !== 3'b010 || RVALID_M0 !== 1'b0) $display("FAIL single_ready: got rdy %b m0 %b expected 010 0", s_rdy, RVALID_M0); else n_pass++;
    @(posedge clk); #1;
    s_id[1] = 8'h1A; s_data[1] = 32'h5A5A_001A;
    #1;
    n_chk++; if ({m_vld, s_rdy} !== 5'b0) $display("FAIL single_back_idle: got %b expected 0", {m_vld, s_rdy}); else n_pass++;
    @(posedge clk); #1;
    n_chk++; if (RVALID_M1 !== 1'b1 || RID_M1 !== 4'hA) $display("FAIL single_next: got vld %b id %h expected 1 a", RVALID_M1, RID_M1); else n_pass++;
    @(posedge clk); #1;
    s_vld[1] = 1'b0;
  endtask

  task automatic test_burst_stall();
    beat_t exp_b [4];
    int    c;
    reset_dut();
    load_burst(0, 8'h02, 4);
    for (int k = 0; k < 4; k++) exp_b[k] = sq[0][k];
    c = 0;
    while ((sq[0].size() > 0 || s_vld[0]) && c < 20) begin
      step((c == 2 || c == 3) ? 2'b00 : 2'b01, 1'b0);
      c++;
    end
    n_chk++; if (rq[0].size() != 4 || rq[1].size() != 0) $display("FAIL burst_count: got m0 %0d m1 %0d expected 4 0", rq[0].size(), rq[1].size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (k >= rq[0].size() || rq[0][k].data !== exp_b[k].data || rq[0][k].last !== (k == 3) || rq[0][k].id !== 8'h02)
        $display("FAIL burst_beat%0d: got %h expected %h last %0d", k, (k < rq[0].size()) ? rq[0][k].data : 32'h0, exp_b[k].data, (k == 3));
      else n_pass++;
    end
  endtask

  task automatic test_contention();
    int c;
    reset_dut();
    load_burst(0, 8'h02, 2);
    load_burst(2, 8'h13, 1);
    c = 0;
    while ((sq[0].size() + sq[2].size() > 0 || s_vld != 3'b000) && c < 30) begin step(2'b11, 1'b0); c++; end
    n_chk++;
    if (done_order.size() != 2 || done_order[0] != 0 || done_order[1] != 2)
      $display("FAIL contention_order: got %0d bursts first %0d second %0d expected S0 then S2", done_order.size(), done_order[0], done_order[1]);
    else n_pass++;
    load_burst(1, 8'h1C, 1);
    load_burst(0, 8'h05, 1);
    c = 0;
    while ((sq[0].size() + sq[1].size() > 0 || s_vld != 3'b000) && c < 30) begin step(2'b11, 1'b0); c++; end
    n_chk++;
    if (done_order.size() != 4 || done_order[2] != 0 || done_order[3] != 1)
      $display("FAIL contention_wrap: got %0d bursts third %0d fourth %0d expected S0 then S1", done_order.size(), done_order[2], done_order[3]);
    else n_pass++;
  endtask

  task automatic test_unmapped();
    int c;
    reset_dut();
    load_burst(2, 8'h51, 3);
    c = 0;
    while ((sq[2].size() > 0 || s_vld[2]) && c < 10) begin
      step(2'b00, 1'b0);
      c++;
      n_chk++; if (m_vld !== 2'b00) $display("FAIL unmapped_no_valid: got %b expected 00", m_vld); else n_pass++;
    end
    n_chk++; if (acc_cnt[2] != 3 || c != 4) $display("FAIL unmapped_drain: got %0d beats in %0d cycles expected 3 in 4", acc_cnt[2], c); else n_pass++;
    n_chk++; if (rq[0].size() + rq[1].size() != 0) $display("FAIL unmapped_leak: got %0d beats at masters expected 0", rq[0].size() + rq[1].size()); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int c;
    reset_dut();
    load_burst(0, 8'h03, 1);
    c = 0;
    while ((sq[0].size() > 0 || s_vld[0]) && c < 10) begin step(2'b11, 1'b0); c++; end
    load_burst(1, 8'h14, 4);
    c = 0;
    while (acc_cnt[1] < 2 && c < 20) begin step(2'b11, 1'b0); c++; end
    n_chk++; if (acc_cnt[1] != 2) $display("FAIL midrst_setup: got %0d beats expected 2", acc_cnt[1]); else n_pass++;
    s_vld[1] = 1'b1; s_id[1] = sq[1][0].id; s_data[1] = sq[1][0].data; s_last[1] = sq[1][0].last;
    s_vld[0] = 1'b1; s_id[0] = 8'h07; s_data[0] = 32'h0000_0707; s_resp[0] = 2'b00; s_last[0] = 1'b1;
    m_rdy = 2'b00; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_chk++; if ({m_vld, s_rdy} !== 5'b0) $display("FAIL midrst_outputs: got %b expected 0", {m_vld, s_rdy}); else n_pass++;
    n_chk++;
    if ({RID_M0, RID_M1, RDATA_M0, RDATA_M1, RRESP_M0, RRESP_M1, m_last} !== '0)
      $display("FAIL midrst_payload: got %h %h expected 0", RDATA_M0, RDATA_M1);
    else n_pass++;
    m_rdy = 2'b11;
    @(posedge clk); #1;
    n_chk++;
    if (m_vld !== 2'b01 || RID_M0 !== 4'h7)
      $display("FAIL midrst_rr_ptr: got valid %b id %h expected 01 7 (S0 first)", m_vld, RID_M0);
    else n_pass++;
    reset_dut();
  endtask

  task automatic test_random();
    int exp_mapped, c, s, r, len;
    logic [3:0] tag;
    reset_dut();
    exp_mapped = 0;
    for (int n = 0; n < 40; n++) begin
      s   = $urandom_range(0, 2);
      r   = $urandom_range(0, 5);
      tag = (r < 4) ? 4'(r % 2) : 4'($urandom_range(2, 15));
      len = $urandom_range(1, 4);
      load_burst(s, {tag, 4'($urandom)}, len);
      if (tag < 4'd2) exp_mapped += len;
    end
    c = 0;
    while ((sq[0].size() + sq[1].size() + sq[2].size() > 0 || s_vld != 3'b000) && c < 3000) begin
      step(2'($urandom), 1'b1);
      c++;
    end
    n_chk++; if (c >= 3000) $display("FAIL random_timeout: got %0d cycles, expected completion", c); else n_pass++;
    n_chk++;
    if (rq[0].size() + rq[1].size() != exp_mapped)
      $display("FAIL random_beats: got %0d beats expected %0d", rq[0].size() + rq[1].size(), exp_mapped);
    else n_pass++;
    n_chk++; if (done_order.size() != 40) $display("FAIL random_bursts: got %0d expected 40", done_order.size()); else n_pass++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; burst_no = 0; owner = -1;
    s_vld = 3'b000; s_last = 3'b000; m_rdy = 2'b00; prev_vld = 2'b00; prev_rdy = 2'b00;
    for (int i = 0; i < 3; i++) begin s_id[i] = '0; s_data[i] = '0; s_resp[i] = '0; acc_cnt[i] = 0; end
    prev_data[0] = '0; prev_data[1] = '0;
    test_reset();
    test_single_beat();
    test_burst_stall();
    test_contention();
    test_unmapped();
    test_reset_mid_burst();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
